aes128_inv_cipher: RTL and testbench
====================================

# aes128_inv_cipher

Iterative AES-128 inverse cipher: decrypts one 128-bit block per request, one round per clock, using the FIPS-197 inverse cipher (InvShiftRows, InvSubBytes, AddRoundKey, InvMixColumns). It is the decrypt-side counterpart of the team's iterative cipher round engine. It sits between the key-schedule store, which it reads through a round-key index port, and the block datapath, which it talks to through a start/done handshake.

## Interface
- N, 128: block and key width; fixed at 128.
- R, 10: number of rounds; fixed at 10.
- clk  in  1  clock; all state changes on the rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- start  in  1  request; sampled only in IDLE.
- cipher_text  in  128  ciphertext; sampled on the cycle start is accepted.
- rk_idx  out  4  round-key index requested from the key store, 0..10.
- round_key  in  128  round key for rk_idx; combinational lookup, valid in the same cycle.
- plain_text  out  128  result register; holds its value until the next completion.
- done  out  1  one-cycle pulse when plain_text is updated.
- busy  out  1  high from the cycle after acceptance until the cycle the result is written.
- roundnum  out  4  current round counter.

## Operation
- Byte order: byte i occupies bits [127-8i -: 8]; the state is column-major, so byte i sits at row i%4, column i/4 (FIPS-197).
- InvShiftRows: out(row r, col c) = in(r, (c-r) mod 4). Row 0 is unchanged; rows 1, 2 and 3 rotate right by 1, 2 and 3.
- InvSubBytes: 256-entry FIPS-197 inverse S-box, for example 63->00 and 16->ff.
- InvMixColumns: each column is multiplied by the matrix {0e,0b,0d,09} (circulant) in GF(2^8), modulo x^8+x^4+x^3+x+1. Build it from a repeated xtime.
- FSM states: IDLE, ROUND, FINAL.
- IDLE: rk_idx=10. When start=1, state_reg <= cipher_text ^ round_key, round_reg <= 9, and the FSM moves to ROUND. If start=0 it stays in IDLE.
- ROUND: rk_idx=round_reg.
  - state_reg <= InvMixColumns(InvSubBytes(InvShiftRows(state_reg)) ^ round_key).
  - round_reg decrements by 1.
  - On round_reg==1 the next state is FINAL and round_reg becomes 0.
- FINAL: rk_idx=0.
  - plain_text <= InvSubBytes(InvShiftRows(state_reg)) ^ round_key. No InvMixColumns in this step.
  - done <= 1 and the FSM returns to IDLE.
- roundnum = round_reg: 0 in IDLE, 9..1 in ROUND, 0 in FINAL.
- start is ignored while busy; it is neither queued nor counted.
- The key input is not stored. The key store must keep round keys 0..10 stable from acceptance until done.

## Timing
- Reset values:
  - FSM: IDLE.
  - round_reg, state_reg, plain_text: 0.
  - done, busy: 0.
  - rk_idx: 10.
- Reset mid-operation: on the next edge with rst_n=0 the block returns to IDLE with all reset values. No done is issued for the aborted block.
- Latency: start is accepted at edge E0. ROUND runs for edges E1..E9 and FINAL for E10. plain_text is valid and done=1 in the cycle after E10, i.e. 10 cycles after acceptance.
- Throughput: one block per 11 cycles. A new start may be accepted in the same cycle done is high, because the FSM is already in IDLE.
- busy is 1 in ROUND and FINAL and 0 in IDLE. busy = (state != IDLE), registered through the state.
- done is high for exactly one cycle per completed block.
- rk_idx sequence per block: 10 (idle/accept), 9, 8, ..., 1, 0. Each value is held for exactly one cycle.
- round_reg is 4 bits wide. Its decrement never wraps, because the exit happens at 1.

## Test plan
- FIPS-197 C.1:
  - Stimulus: key 000102030405060708090a0b0c0d0e0f (bench supplies the key schedule; rk10 = 13111d7fe3944a17f307a78b4d2b30c5), cipher_text 69c4e0d86a7b0430d8cdb78070b4c55a.
  - Required: plain_text 00112233445566778899aabbccddeeff, with done exactly 10 cycles after acceptance.
- FIPS-197 Appendix B:
  - Stimulus: key 2b7e151628aed2a6abf7158809cf4f3c, cipher_text 3925841d02dc09fbdc118597196a0b32.
  - Required: plain_text 3243f6a8885a308d313198a2e0370734.
  - Also required: rk_idx observed as 10, 9, ..., 0 and roundnum as 9..1, 0.
- Back-to-back:
  - Stimulus: key all-zero, cipher_text 66e94bd4ef8a2c3b884cfa59ca342b2e, then the C.1 vector applied with start raised in the done cycle.
  - Required: results 0000...0000 and then 00112233...eeff, separated by 11 cycles, with one done pulse each.
- Start while busy:
  - Stimulus: pulse start at cycles 3 and 7 after acceptance with a different cipher_text.
  - Required: the first result is unaffected and there is exactly one done.
- Reset mid-operation:
  - Stimulus: drive rst_n=0 for 1 cycle at round 5.
  - Required: next cycle shows busy=0, done=0, plain_text=0, roundnum=0 and rk_idx=10; no done ever follows.
  - Then: a fresh C.1 request decrypts correctly.
- Idle hold:
  - Stimulus: after a completion, keep start=0 for 20 cycles while toggling cipher_text.
  - Required: plain_text is unchanged and done stays 0.

Source files
------------

// File: rtl/aes128_inv_cipher.sv
// aes128_inv_cipher
// Iterative AES-128 inverse cipher (FIPS-197). Decrypts one 128-bit block per
// request, one round per clock. Round keys come from an external key store
// through a combinational index/lookup port.
//
// Ports:
//   clk          clock, rising edge
//   rst_n        synchronous active-low reset
//   start        request, sampled only while idle
//   cipher_text  ciphertext, captured when start is accepted
//   rk_idx       round-key index presented to the key store (10 .. 0)
//   round_key    round key for rk_idx, same-cycle lookup
//   plain_text   result register, held until the next completion
//   done         one-cycle pulse when plain_text is updated
//   busy         high while a block is in flight
//   roundnum     current round counter
module aes128_inv_cipher #(
  parameter int N = 128,
  parameter int R = 10
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [N-1:0] cipher_text,
  output logic [3:0]   rk_idx,
  input  logic [N-1:0] round_key,
  output logic [N-1:0] plain_text,
  output logic         done,
  output logic         busy,
  output logic [3:0]   roundnum
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ROUND = 2'd1,
    FINAL = 2'd2
  } state_t;

  // Inverse S-box, entry x at bits [2047-8x -: 8].
  localparam logic [2047:0] INV_SBOX_FLAT = {
    128'h52096ad53036a538bf40a39e81f3d7fb,
    128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e,
    128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692,
    128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506,
    128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673,
    128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b,
    128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f,
    128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961,
    128'h172b047eba77d626e169146355210c7d
  };

  state_t         r_state;
  state_t         w_state_next;
  logic [N-1:0]   r_block;
  logic [3:0]     r_round;
  logic [N-1:0]   r_plain;
  logic           r_done;
  logic [N-1:0]   w_ark;
  logic [N-1:0]   w_round_out;

  function automatic logic [7:0] inv_sbox(input logic [7:0] b);
    int unsigned idx;
    idx = 32'(b);
    return INV_SBOX_FLAT[2047 - 8*idx -: 8];
  endfunction

  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // Byte i lives at row i%4, column i/4; row r rotates right by r.
  function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
    logic [127:0] o;
    int unsigned  src;
    o = '0;
    for (int unsigned c = 0; c < 4; c++) begin
      for (int unsigned r = 0; r < 4; r++) begin
        src = (c + 4 - r) % 4;
        o[127 - 8*(4*c + r) -: 8] = s[127 - 8*(4*src + r) -: 8];
      end
    end
    return o;
  endfunction

  function automatic logic [127:0] inv_sub_bytes(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int unsigned i = 0; i < 16; i++) begin
      o[127 - 8*i -: 8] = inv_sbox(s[127 - 8*i -: 8]);
    end
    return o;
  endfunction

  // Multiples 09/0b/0d/0e built from x2, x4, x8 (repeated xtime).
  function automatic logic [31:0] inv_mix_col(input logic [31:0] col);
    logic [7:0] a  [4];
    logic [7:0] m9 [4];
    logic [7:0] mb [4];
    logic [7:0] md [4];
    logic [7:0] me [4];
    logic [7:0] x2, x4, x8;
    for (int unsigned i = 0; i < 4; i++) begin
      a[i]  = col[31 - 8*i -: 8];
      x2    = xt(a[i]);
      x4    = xt(x2);
      x8    = xt(x4);
      m9[i] = x8 ^ a[i];
      mb[i] = x8 ^ x2 ^ a[i];
      md[i] = x8 ^ x4 ^ a[i];
      me[i] = x8 ^ x4 ^ x2;
    end
    return {me[0] ^ mb[1] ^ md[2] ^ m9[3],
            m9[0] ^ me[1] ^ mb[2] ^ md[3],
            md[0] ^ m9[1] ^ me[2] ^ mb[3],
            mb[0] ^ md[1] ^ m9[2] ^ me[3]};
  endfunction

  function automatic logic [127:0] inv_mix_columns(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int unsigned c = 0; c < 4; c++) begin
      o[127 - 32*c -: 32] = inv_mix_col(s[127 - 32*c -: 32]);
    end
    return o;
  endfunction

  // ROUND and FINAL share the shift/sub/add-key path; only ROUND mixes.
  always_comb begin
    w_ark       = inv_sub_bytes(inv_shift_rows(r_block)) ^ round_key;
    w_round_out = inv_mix_columns(w_ark);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    rk_idx       = 4'(R);
    busy         = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (start) w_state_next = ROUND;
      end
      ROUND: begin
        busy   = 1'b1;
        rk_idx = r_round;
        if (r_round == 4'd1) w_state_next = FINAL;
      end
      FINAL: begin
        busy         = 1'b1;
        rk_idx       = '0;
        w_state_next = IDLE;
      end
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_block <= '0;
      r_round <= '0;
      r_plain <= '0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      unique case (r_state)
        IDLE: begin
          if (start) begin
            r_block <= cipher_text ^ round_key;
            r_round <= 4'(R - 1);
          end
        end
        ROUND: begin
          r_block <= w_round_out;
          r_round <= r_round - 4'd1;
        end
        FINAL: begin
          r_plain <= w_ark;
          r_done  <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign plain_text = r_plain;
  assign done       = r_done;
  assign roundnum   = r_round;

endmodule

// File: tb/tb_aes128_inv_cipher.sv
// Testbench for aes128_inv_cipher: FIPS-197 vectors, handshake corner cases and
// randomized traffic checked against a byte-array reference model of AES-128
// decryption whose S-box is derived from GF(2^8) arithmetic.
module tb_aes128_inv_cipher;

  localparam logic [127:0] C1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] C1_PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] B_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] B_CT   = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] B_PT   = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] Z_CT   = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [127:0] cipher_text;
  logic [3:0]   rk_idx;
  logic [127:0] round_key;
  logic [127:0] plain_text;
  logic         done;
  logic         busy;
  logic [3:0]   roundnum;

  always #5 clk = ~clk;

  aes128_inv_cipher #(.N(128), .R(10)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .cipher_text (cipher_text),
    .rk_idx      (rk_idx),
    .round_key   (round_key),
    .plain_text  (plain_text),
    .done        (done),
    .busy        (busy),
    .roundnum    (roundnum)
  );

  logic [127:0] rks [11];
  logic [7:0]   sbox  [256];
  logic [7:0]   isbox [256];

  int errors = 0;
  int checks = 0;
  int cyc    = 0;
  int n_done = 0;
  int m_k    = 0;
  logic         m_done = 1'b0;
  logic [127:0] m_pt   = '0;
  logic [127:0] m_pend = '0;
  logic         cmp_en = 1'b0;

  // Key store: combinational lookup
  always_comb begin
    round_key = '0;
    if (rk_idx <= 4'd10) round_key = rks[rk_idx];
  end

  function automatic void chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h (t=%0t)", name, act, exp, $time);
    end
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, aa, bb;
    p = 8'h00; aa = a; bb = b;
    for (int i = 0; i < 8; i++) begin
      if (bb[0]) p = p ^ aa;
      aa = aa[7] ? ({aa[6:0], 1'b0} ^ 8'h1b) : {aa[6:0], 1'b0};
      bb = {1'b0, bb[7:1]};
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
    logic [15:0] d;
    d = {b, b} << n;
    return d[15:8];
  endfunction

  // S-box = affine transform of the multiplicative inverse; inverse table by inversion.
  task automatic build_tables();
    logic [7:0] inv, s;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++) begin
        if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      end
      s = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
      sbox[x]  = s;
      isbox[s] = 8'(x);
    end
  endtask

  task automatic set_key(input logic [127:0] key);
    logic [31:0] w [44];
    logic [31:0] t;
    logic [7:0]  rc;
    rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[127 - 32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {sbox[t[23:16]], sbox[t[15:8]], sbox[t[7:0]], sbox[t[31:24]]} ^ {rc, 24'h0};
        rc = gmul(rc, 8'h02);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r < 11; r++) rks[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  function automatic logic [127:0] model_dec(input logic [127:0] ct);
    logic [7:0]   s [16];
    logic [7:0]   t [16];
    logic [7:0]   coef [4];
    logic [127:0] k, o;
    logic [7:0]   acc;
    coef[0] = 8'h0e; coef[1] = 8'h0b; coef[2] = 8'h0d; coef[3] = 8'h09;
    k = rks[10];
    for (int i = 0; i < 16; i++) s[i] = ct[127 - 8*i -: 8] ^ k[127 - 8*i -: 8];
    for (int rnd = 9; rnd >= 0; rnd--) begin
      k = rks[rnd];
      for (int c = 0; c < 4; c++)
        for (int r = 0; r < 4; r++)
          t[r + 4*c] = isbox[s[r + 4*((c - r + 4) % 4)]];
      for (int i = 0; i < 16; i++) t[i] = t[i] ^ k[127 - 8*i -: 8];
      if (rnd > 0) begin
        for (int c = 0; c < 4; c++)
          for (int r = 0; r < 4; r++) begin
            acc = 8'h00;
            for (int j = 0; j < 4; j++) acc = acc ^ gmul(coef[(j - r + 4) % 4], t[j + 4*c]);
            s[r + 4*c] = acc;
          end
      end else begin
        for (int i = 0; i < 16; i++) s[i] = t[i];
      end
    end
    o = '0;
    for (int i = 0; i < 16; i++) o[127 - 8*i -: 8] = s[i];
    return o;
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  // Transaction-level expectation: m_k counts edges since acceptance (0 = idle).
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (!rst_n) begin
      m_k    <= 0;
      m_done <= 1'b0;
      m_pt   <= '0;
    end else begin
      m_done <= 1'b0;
      if (m_k == 0) begin
        if (start) begin
          m_k    <= 1;
          m_pend <= model_dec(cipher_text);
        end
      end else if (m_k == 10) begin
        m_k    <= 0;
        m_pt   <= m_pend;
        m_done <= 1'b1;
      end else begin
        m_k <= m_k + 1;
      end
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("busy", 128'(busy), 128'(m_k != 0));
      chk("done", 128'(done), 128'(m_done));
      chk("plain_text", plain_text, m_pt);
      chk("roundnum", 128'(roundnum), 128'((m_k >= 1 && m_k <= 9) ? 10 - m_k : 0));
      chk("rk_idx", 128'(rk_idx), 128'((m_k == 0) ? 10 : 10 - m_k));
      if (done) n_done <= n_done + 1;
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic do_req(input logic [127:0] ct, output int acc);
    start       = 1'b1;
    cipher_text = ct;
    tick();
    acc   = cyc;
    start = 1'b0;
  endtask

  task automatic wait_done();
    logic ok;
    ok = 1'b0;
    for (int i = 0; i < 40 && !ok; i++) begin
      tick();
      if (done) ok = 1'b1;
    end
    if (!ok) chk("done_timeout", 128'(0), 128'(1));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=running required=finished");
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1);
  end

  initial begin
    int acc, t1, d0;
    logic [127:0] saved;

    rst_n = 1'b0; start = 1'b0; cipher_text = '0;
    build_tables();
    chk("model_isbox_63", 128'(isbox[8'h63]), 128'h00);
    chk("model_isbox_16", 128'(isbox[8'h16]), 128'hff);
    set_key(B_KEY);
    chk("model_B", model_dec(B_CT), B_PT);
    set_key(C1_KEY);
    chk("model_rk10_C1", rks[10], 128'h13111d7fe3944a17f307a78b4d2b30c5);
    chk("model_C1", model_dec(C1_CT), C1_PT);

    tick();
    cmp_en = 1'b1;
    tick();
    chk("rst_busy", 128'(busy), 128'(0));
    chk("rst_done", 128'(done), 128'(0));
    chk("rst_pt", plain_text, 128'h0);
    chk("rst_roundnum", 128'(roundnum), 128'(0));
    chk("rst_rk_idx", 128'(rk_idx), 128'(10));
    rst_n = 1'b1;
    tick();

    // FIPS-197 C.1 with latency
    do_req(C1_CT, acc);
    wait_done();
    chk("c1_latency", 128'(cyc - acc), 128'(10));
    chk("c1_pt", plain_text, C1_PT);

    // Appendix B with rk_idx / roundnum trace
    set_key(B_KEY);
    tick();
    chk("b_rk_idle", 128'(rk_idx), 128'(10));
    start = 1'b1; cipher_text = B_CT;
    for (int j = 1; j <= 10; j++) begin
      tick();
      start = 1'b0;
      chk("b_rk_idx", 128'(rk_idx), 128'(10 - j));
      chk("b_roundnum", 128'(roundnum), 128'((j <= 9) ? 10 - j : 0));
    end
    tick();
    chk("b_done", 128'(done), 128'(1));
    chk("b_pt", plain_text, B_PT);

    // Back-to-back: start in the done cycle
    set_key('0);
    d0 = n_done;
    do_req(Z_CT, acc);
    wait_done();
    chk("b2b_pt0", plain_text, 128'h0);
    chk("b2b_done0", 128'(n_done - d0), 128'(1));
    t1 = cyc; d0 = n_done;
    set_key(C1_KEY);
    do_req(C1_CT, acc);
    wait_done();
    chk("b2b_spacing", 128'(cyc - t1), 128'(11));
    chk("b2b_pt1", plain_text, C1_PT);
    chk("b2b_done1", 128'(n_done - d0), 128'(1));

    // Start while busy
    tick();
    d0 = n_done;
    do_req(C1_CT, acc);
    tick(); tick();
    start = 1'b1; cipher_text = rand128();
    tick();
    start = 1'b0;
    tick(); tick(); tick();
    start = 1'b1; cipher_text = rand128();
    tick();
    start = 1'b0;
    wait_done();
    chk("busy_start_pt", plain_text, C1_PT);
    repeat (12) tick();
    chk("busy_start_dones", 128'(n_done - d0), 128'(1));

    // Reset mid-operation
    do_req(C1_CT, acc);
    for (int i = 0; i < 12 && roundnum != 4'd5; i++) tick();
    chk("mid_reach_round5", 128'(roundnum), 128'(5));
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("mid_busy", 128'(busy), 128'(0));
    chk("mid_done", 128'(done), 128'(0));
    chk("mid_pt", plain_text, 128'h0);
    chk("mid_roundnum", 128'(roundnum), 128'(0));
    chk("mid_rk_idx", 128'(rk_idx), 128'(10));
    d0 = n_done;
    repeat (15) tick();
    chk("mid_no_done", 128'(n_done - d0), 128'(0));
    do_req(C1_CT, acc);
    wait_done();
    chk("mid_fresh_pt", plain_text, C1_PT);

    // Idle hold
    saved = plain_text; d0 = n_done;
    for (int i = 0; i < 20; i++) begin
      cipher_text = rand128();
      tick();
    end
    chk("idle_pt", plain_text, saved);
    chk("idle_dones", 128'(n_done - d0), 128'(0));

    // Randomized traffic
    for (int n = 0; n < 25; n++) begin
      logic [127:0] ct, exp;
      set_key(rand128());
      repeat ($urandom_range(0, 3)) tick();
      ct  = rand128();
      exp = model_dec(ct);
      do_req(ct, acc);
      for (int j = 0; j < 8; j++) begin
        start       = ($urandom_range(0, 3) == 0);
        cipher_text = rand128();
        tick();
      end
      start = 1'b0;
      wait_done();
      chk("rand_pt", plain_text, exp);
    end

    repeat (3) tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
